alu_rr_scheduler: RTL and testbench

ALU_RR_SCHEDULER -- requirements
Module: alu_rr_scheduler

---
 rtl/alu_rr_scheduler_pkg.sv | 21 ++
 rtl/alu_rr_scheduler_rr_arbiter.sv | 31 +++
 rtl/alu_rr_scheduler.sv | 163 ++++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rr_scheduler_pkg.sv
// Shared definitions for the round-robin ALU scheduler: FSM state
// encoding, ALU opcode values and the response flag packing helper.
package alu_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    // Response flags are ordered {overflow, zero, carry}.
    function automatic logic [2:0] pack_flags(input logic ovf, input logic zero, input logic carry);
        return {ovf, zero, carry};
    endfunction

endpackage

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// Purely combinational round-robin arbiter: grants the first set request
// found when searching upward from ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant
);

    logic found_s;
    int   idx_s;

    // Rotating priority search starting at ptr; at most one grant bit set.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = (int'(ptr) + k) % NREQ;
            if (!found_s && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one external ALU between NREQ requesters. A round-robin grant
// accepts one operation, the operands are held on the ALU, the result is
// captured and offered as a response, then the next request is accepted.
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ALU_LAT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [4*NREQ-1:0]   req_a,
    input  logic [4*NREQ-1:0]   req_b,
    input  logic [2*NREQ-1:0]   req_op,
    output logic [NREQ-1:0]     req_ready,
    output logic [3:0]          alu_a,
    output logic [3:0]          alu_b,
    output logic [1:0]          alu_op,
    input  logic [3:0]          alu_result,
    input  logic                alu_carry,
    input  logic                alu_zero,
    input  logic                alu_overflow,
    output logic                rsp_valid,
    output logic [2:0]          rsp_id,
    output logic [3:0]          rsp_result,
    output logic [2:0]          rsp_flags,
    input  logic                rsp_ready,
    output logic                busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [2:0]       id_q, id_d;
    logic [3:0]       a_q, a_d, b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [2:0]       rsp_id_q, rsp_id_d;
    logic [3:0]       rsp_result_q, rsp_result_d;
    logic [2:0]       rsp_flags_q, rsp_flags_d;

    logic [NREQ-1:0]  grant_s;
    logic [NREQ-1:0]  req_ready_s;
    logic             accept_s;
    int               gnt_idx_s;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant_s)
    );

    assign req_ready_s = (state_q == ST_IDLE) ? grant_s : '0;
    assign accept_s    = |(req_valid & req_ready_s);

    // Convert the one-hot grant into a requester index.
    always_comb begin
        gnt_idx_s = 0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_idx_s = grant_s[i] ? i : gnt_idx_s;
        end
    end

    // Next-state logic. EXEC is one launch cycle followed by ALU_LAT
    // counted cycles, so the result is sampled ALU_LAT+1 edges after accept.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    a_d     = req_a[4*gnt_idx_s +: 4];
                    b_d     = req_b[4*gnt_idx_s +: 4];
                    op_d    = req_op[2*gnt_idx_s +: 2];
                    id_d    = 3'(gnt_idx_s);
                    ptr_d   = (gnt_idx_s == NREQ - 1) ? '0 : PTR_W'(gnt_idx_s + 1);
                    cnt_d   = 4'd0;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_q == 4'(ALU_LAT)) begin
                    rsp_result_d = alu_result;
                    rsp_flags_d  = pack_flags(alu_overflow, alu_zero, alu_carry);
                    rsp_id_d     = id_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            cnt_q        <= 4'd0;
            id_q         <= 3'd0;
            a_q          <= 4'd0;
            b_q          <= 4'd0;
            op_q         <= 2'd0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 3'd0;
            rsp_result_q <= 4'd0;
            rsp_flags_q  <= 3'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign req_ready  = req_ready_s;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler: directed scenarios followed by
// randomized transactions checked against an arithmetic reference model.
module tb_alu_rr_scheduler;
    import alu_sched_pkg::*;

    localparam int NREQ    = 4;
    localparam int ALU_LAT = 3;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [4*NREQ-1:0]   req_a;
    logic [4*NREQ-1:0]   req_b;
    logic [2*NREQ-1:0]   req_op;
    logic [NREQ-1:0]     req_ready;
    logic [3:0]          alu_a;
    logic [3:0]          alu_b;
    logic [1:0]          alu_op;
    logic [3:0]          alu_result;
    logic                alu_carry;
    logic                alu_zero;
    logic                alu_overflow;
    logic                rsp_valid;
    logic [2:0]          rsp_id;
    logic [3:0]          rsp_result;
    logic [2:0]          rsp_flags;
    logic                rsp_ready;
    logic                busy;

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_m    = 0;
    int ids_seen[$];
    int last_id, last_res, last_flags, last_lat;
    int w;
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};

    alu_rr_scheduler #(
        .NREQ    (NREQ),
        .ALU_LAT (ALU_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .req_ready    (req_ready),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .rsp_ready    (rsp_ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU stand-in, bit-level formulation.
    logic [4:0] alu_wide_s;
    always_comb begin
        alu_wide_s   = 5'd0;
        alu_result   = 4'd0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_op)
            2'b00: begin
                alu_wide_s   = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result   = alu_wide_s[3:0];
                alu_carry    = alu_wide_s[4];
                alu_overflow = (alu_a[3] == alu_b[3]) && (alu_result[3] != alu_a[3]);
            end
            2'b01: begin
                alu_wide_s   = {1'b0, alu_a} - {1'b0, alu_b};
                alu_result   = alu_wide_s[3:0];
                alu_carry    = alu_wide_s[4];
                alu_overflow = (alu_a[3] != alu_b[3]) && (alu_result[3] != alu_a[3]);
            end
            2'b10:   alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
        alu_zero = (alu_result == 4'd0);
    end

    // Expected result/flags from integer arithmetic on the operands.
    function automatic void ref_op(input int a, input int b, input int op,
                                   output int res, output int flags);
        int sa, sb, s, sv;
        bit c, v;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        c = 1'b0; v = 1'b0; s = 0; sv = 0;
        case (op)
            0: begin s = a + b; sv = sa + sb; c = (s > 15); v = (sv > 7) || (sv < -8); res = s % 16; end
            1: begin s = a - b; sv = sa - sb; c = (s < 0);  v = (sv > 7) || (sv < -8); res = (s + 16) % 16; end
            2: res = a & b;
            default: res = a | b;
        endcase
        flags = (v ? 4 : 0) + ((res == 0) ? 2 : 0) + (c ? 1 : 0);
    endfunction

    function automatic int rr_model(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        @(posedge clk); #1;
    endtask

    // One full transaction from IDLE; starts and ends 1 time unit after a rising edge.
    task automatic run_txn(input logic [NREQ-1:0] v, input logic [4*NREQ-1:0] a,
                           input logic [4*NREQ-1:0] b, input logic [2*NREQ-1:0] op,
                           input int hold, output int wout);
        int ea, eb, eop, er, ef, n;
        req_valid = v; req_a = a; req_b = b; req_op = op; rsp_ready = 1'b0;
        #1;
        wout = rr_model(v);
        chk("req_ready_grant", 32'(req_ready), (wout < 0) ? 32'd0 : 32'(1 << wout));
        if (wout < 0) begin
            @(posedge clk); #1;
            chk("idle_busy", 32'(busy), 32'd0);
            return;
        end
        ea  = int'(a[4*wout +: 4]);
        eb  = int'(b[4*wout +: 4]);
        eop = int'(op[2*wout +: 2]);
        ref_op(ea, eb, eop, er, ef);
        @(posedge clk); #1;
        ptr_m = (wout + 1) % NREQ;
        req_valid = NREQ'($urandom); req_a = 16'($urandom); req_b = 16'($urandom); req_op = 8'($urandom);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 4 * ALU_LAT + 8) begin
            chk("exec_busy", 32'(busy), 32'd1);
            chk("exec_req_ready", 32'(req_ready), 32'd0);
            chk("exec_alu_a", 32'(alu_a), 32'(ea));
            chk("exec_alu_b", 32'(alu_b), 32'(eb));
            chk("exec_alu_op", 32'(alu_op), 32'(eop));
            @(posedge clk); #1;
            n++;
        end
        last_lat = n; last_id = int'(rsp_id); last_res = int'(rsp_result); last_flags = int'(rsp_flags);
        ids_seen.push_back(last_id);
        chk("latency", 32'(n), 32'(ALU_LAT + 1));
        chk("rsp_id", 32'(rsp_id), 32'(wout));
        chk("rsp_result", 32'(rsp_result), 32'(er));
        chk("rsp_flags", 32'(rsp_flags), 32'(ef));
        repeat (hold) begin
            req_valid = NREQ'($urandom) | NREQ'(1);
            @(posedge clk); #1;
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_id", 32'(rsp_id), 32'(wout));
            chk("hold_rsp_result", 32'(rsp_result), 32'(er));
            chk("hold_rsp_flags", 32'(rsp_flags), 32'(ef));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("idle_alu_a_hold", 32'(alu_a), 32'(ea));
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_payload", 32'({rsp_id, rsp_result, rsp_flags}), 32'd0);
        chk("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        do_reset();

        // Add F+1 on requester 0.
        run_txn(4'b0001, 16'h000F, 16'h0001, {4{OP_ADD}}, 0, w);
        chk("t032_id", 32'(last_id), 32'd0);
        chk("t032_lat", 32'(last_lat), 32'd4);
        chk("t032_result", 32'(last_res), 32'h0);
        chk("t032_flags", 32'(last_flags), 32'b011);

        // All requesters valid: fair rotation from ptr 0.
        do_reset();
        ids_seen.delete();
        for (int i = 0; i < 6; i++) begin
            run_txn(4'hF, 16'($urandom), 16'($urandom), 8'($urandom), 0, w);
        end
        for (int i = 0; i < 6; i++) begin
            chk("t033_order", 32'((i < ids_seen.size()) ? ids_seen[i] : -1), 32'(exp_order[i]));
        end

        // Pointer skipping and wrap.
        do_reset();
        run_txn(4'b0100, 16'($urandom), 16'($urandom), 8'($urandom), 0, w);
        chk("t034_first", 32'(last_id), 32'd2);
        run_txn(4'b1010, 16'($urandom), 16'($urandom), 8'($urandom), 0, w);
        chk("t034_second", 32'(last_id), 32'd3);

        // Subtract 3-5 on requester 1 with consumer back-pressure.
        run_txn(4'b0010, 16'h0030, 16'h0050, {2'b00, 2'b00, OP_SUB, 2'b00}, 5, w);
        chk("t035_id", 32'(last_id), 32'd1);
        chk("t035_result", 32'(last_res), 32'hE);
        chk("t035_flags", 32'(last_flags), 32'b001);

        // Reset during the second EXEC cycle.
        do_reset();
        req_valid = 4'b0001; req_a = 16'h0007; req_b = 16'h0002; req_op = 8'h00;
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        chk("t036_busy_pre", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t036_busy", 32'(busy), 32'd0);
        chk("t036_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t036_payload", 32'({rsp_id, rsp_result, rsp_flags}), 32'd0);
        chk("t036_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        chk("t036_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("t036_no_rsp", 32'(rsp_valid), 32'd0);
            chk("t036_idle", 32'(busy), 32'd0);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            run_txn(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 8'($urandom),
                    $urandom_range(0, 3), w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
